pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator: one shared period counter, CHANNELS independent compare outputs, and a small write-only register interface. TOP and compare writes are double-buffered and reach the active registers only at a period boundary, so outputs never glitch mid-period. Sits beside the timer blocks and drives motor, LED and buzzer pins; it is the general successor to the single-channel 16-bit PWM.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_channel.sv | 56 +++++
 rtl/pwm_multi.sv | 185 ++++++++++++++++++
 tb/tb_pwm_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants and types for the pwm_multi block:
//            register address map, CTRL bit positions and the counting
//            direction enum used by center-aligned mode.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Register address map (write-only interface)
  localparam int PWM_ADDR_CTRL = 0;
  localparam int PWM_ADDR_TOP  = 1;
  localparam int PWM_ADDR_CNT  = 2;
  localparam int PWM_ADDR_CMP0 = 3;   // CMP[i] lives at PWM_ADDR_CMP0 + i

  // CTRL register bit positions
  localparam int PWM_CTRL_EN_BIT     = 0;
  localparam int PWM_CTRL_CENTER_BIT = 1;

  // Counting direction (only meaningful in center-aligned mode)
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM compare channel: double-buffered compare register
//            (shadow + active) and the output comparator.
// Ports    : clk_i     - clock
//            rst_ni    - asynchronous active-low reset
//            wr_i      - write strobe for this channel's compare shadow
//            wdata_i   - write data
//            load_i    - shadow->active copy strobe (boundary or disabled)
//            en_i      - global enable; output forced low when 0
//            cnt_i     - shared period counter value
//            out_o     - PWM output (cnt < active compare)
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             out_o
);

  logic [WIDTH-1:0] cmp_sh_q,  cmp_sh_d;
  logic [WIDTH-1:0] cmp_act_q, cmp_act_d;

  // A write coinciding with a load bypasses the shadow so the new value
  // is not lost for a whole period.
  always_comb begin
    cmp_sh_d  = wr_i ? wdata_i : cmp_sh_q;
    cmp_act_d = cmp_act_q;
    if (load_i) begin
      cmp_act_d = wr_i ? wdata_i : cmp_sh_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_sh_q  <= '0;
      cmp_act_q <= '0;
    end else begin
      cmp_sh_q  <= cmp_sh_d;
      cmp_act_q <= cmp_act_d;
    end
  end

  // cmp=0 gives constant low; cmp>top gives constant high.
  assign out_o = en_i && (cnt_i < cmp_act_q);

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel PWM generator with one shared period counter,
//            CHANNELS compare outputs and a write-only register interface.
//            TOP and CMP writes are double-buffered and take effect at a
//            period boundary (or on the next edge while disabled).
// Config   : PWM_CENTER_ALIGN_EN - when defined, CTRL bit1 (CENTER) and the
//            direction flop exist and center-aligned counting is available.
//            When undefined the block is edge-aligned only.
// Ports    : clk_i    - clock, all state on rising edge
//            rst_ni   - asynchronous active-low reset
//            we_i     - register write strobe
//            addr_i   - register address (0 CTRL, 1 TOP, 2 CNT, 3+i CMP[i])
//            wdata_i  - write data
//            cnt_o    - current counter value
//            top_o    - active TOP
//            wrap_o   - one-cycle pulse on period boundary
//            out_o    - PWM outputs
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,                     // 1..16
  parameter int AW       = $clog2(CHANNELS + 3)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic [WIDTH-1:0]    cnt_o,
  output logic [WIDTH-1:0]    top_o,
  output logic                wrap_o,
  output logic [CHANNELS-1:0] out_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // --------------------------------------------------------------------------
  // Register decode
  // --------------------------------------------------------------------------
  logic w_wr_ctrl, w_wr_top, w_wr_cnt;

  assign w_wr_ctrl = we_i && (addr_i == AW'(PWM_ADDR_CTRL));
  assign w_wr_top  = we_i && (addr_i == AW'(PWM_ADDR_TOP));
  assign w_wr_cnt  = we_i && (addr_i == AW'(PWM_ADDR_CNT));

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             en_q,      en_d;
  logic [WIDTH-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] top_sh_q,  top_sh_d;
  logic [WIDTH-1:0] top_act_q, top_act_d;

  logic w_center;     // center-aligned mode selected
  logic w_dir_down;   // counter currently counting down
  logic w_wrap;       // period boundary this cycle
  logic w_boundary;   // boundary that is allowed to copy shadows
  logic w_load;       // shadow->active copy strobe

`ifdef PWM_CENTER_ALIGN_EN
  logic     center_q, center_d;
  pwm_dir_e dir_q,    dir_d;

  assign w_center   = center_q;
  assign w_dir_down = (dir_q == DIR_DOWN);

  assign center_d = w_wr_ctrl ? wdata_i[PWM_CTRL_CENTER_BIT] : center_q;

  always_comb begin
    dir_d = dir_q;
    if (w_wr_cnt) begin
      // A load above TOP can only come back into range by counting down.
      if (center_q && (wdata_i > top_act_q)) begin
        dir_d = DIR_DOWN;
      end
    end else if (en_q && center_q) begin
      if (top_act_q == '0) begin
        dir_d = DIR_UP;
      end else if ((dir_q == DIR_UP) && (cnt_q >= top_act_q)) begin
        dir_d = DIR_DOWN;
      end else if ((dir_q == DIR_DOWN) && (cnt_q == '0)) begin
        dir_d = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      center_q <= 1'b0;
      dir_q    <= DIR_UP;
    end else begin
      center_q <= center_d;
      dir_q    <= dir_d;
    end
  end
`else
  assign w_center   = 1'b0;
  assign w_dir_down = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Boundary detection (flops only, no input-to-output path)
  // --------------------------------------------------------------------------
  assign w_wrap = en_q && ((top_act_q == '0) ||
                           (!w_center && (cnt_q >= top_act_q)) ||
                           (w_center && w_dir_down && (cnt_q == '0)));

  // A CNT write overrides counting, so it also suppresses the shadow copy.
  assign w_boundary = w_wrap && !w_wr_cnt;
  assign w_load     = !en_q || w_boundary;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    en_d      = w_wr_ctrl ? wdata_i[PWM_CTRL_EN_BIT] : en_q;
    top_sh_d  = w_wr_top ? wdata_i : top_sh_q;
    top_act_d = top_act_q;
    if (w_load) begin
      top_act_d = w_wr_top ? wdata_i : top_sh_q;
    end

    cnt_d = cnt_q;
    if (w_wr_cnt) begin
      cnt_d = wdata_i;
    end else if (en_q) begin
      if (top_act_q == '0) begin
        cnt_d = '0;
      end else if (!w_center) begin
        cnt_d = (cnt_q >= top_act_q) ? '0 : cnt_q + ONE;
      end else if (!w_dir_down) begin
        // Turn around at TOP without repeating it: next value is TOP-1.
        cnt_d = (cnt_q >= top_act_q) ? top_act_q - ONE : cnt_q + ONE;
      end else begin
        cnt_d = (cnt_q == '0) ? ONE : cnt_q - ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      cnt_q     <= '0;
      top_sh_q  <= '0;
      top_act_q <= '0;
    end else begin
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      top_sh_q  <= top_sh_d;
      top_act_q <= top_act_d;
    end
  end

  // --------------------------------------------------------------------------
  // Channels
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic w_wr_cmp;
    assign w_wr_cmp = we_i && (addr_i == AW'(PWM_ADDR_CMP0 + gi));

    pwm_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_i    (w_wr_cmp),
      .wdata_i (wdata_i),
      .load_i  (w_load),
      .en_i    (en_q),
      .cnt_i   (cnt_q),
      .out_o   (out_o[gi])
    );
  end

  assign cnt_o  = cnt_q;
  assign top_o  = top_act_q;
  assign wrap_o = w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Self-checking bench for pwm_multi (WIDTH=16, CHANNELS=4).
//            Register setup is table driven; free-running behaviour is
//            checked through a scoreboard of per-cycle expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] cnt_o;
  logic [15:0] top_o;
  logic        wrap_o;
  logic [3:0]  out_o;

  int checks   = 0;
  int failures = 0;

  pwm_multi #(
    .WIDTH    (16),
    .CHANNELS (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .cnt_o   (cnt_o),
    .top_o   (top_o),
    .wrap_o  (wrap_o),
    .out_o   (out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] top;
    logic        wrap;
    logic [3:0]  out;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] cnt;
    logic [15:0] top;
    logic        wrap;
    logic [3:0]  out;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk(tag, "cnt",  32'(cnt_o),  32'(e.cnt));
    chk(tag, "top",  32'(top_o),  32'(e.top));
    chk(tag, "wrap", 32'(wrap_o), 32'(e.wrap));
    chk(tag, "out",  32'(out_o),  32'(e.out));
  endtask

  // Drive one cycle (optionally with a write), then compare after the edge.
  task automatic cyc(input string tag, input logic w, input logic [2:0] a,
                     input logic [15:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    check_now(tag);
  endtask

  task automatic push_raw(input int c, input int t, input bit w, input logic [3:0] o);
    exp_t e;
    e.cnt  = 16'(c);
    e.top  = 16'(t);
    e.wrap = w;
    e.out  = o;
    sb.push_back(e);
  endtask

  // Edge-mode expectation with CMP1=0, CMP2=20, CMP3=10 fixed.
  task automatic push_edge(input int c, input int t, input int cmp0, input bit en);
    logic [3:0] o;
    o = en ? {(c < 10), (c < 20), 1'b0, (c < cmp0)} : 4'b0000;
    push_raw(c, t, en && (c >= t), o);
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;

    // Register setup while disabled, then enable.
    tbl[0] = '{1'b1, 3'd1, 16'd9,      16'd0, 16'd9, 1'b0, 4'b0000}; // TOP=9
    tbl[1] = '{1'b1, 3'd3, 16'd3,      16'd0, 16'd9, 1'b0, 4'b0000}; // CMP0=3
    tbl[2] = '{1'b1, 3'd4, 16'd0,      16'd0, 16'd9, 1'b0, 4'b0000}; // CMP1=0
    tbl[3] = '{1'b1, 3'd5, 16'd20,     16'd0, 16'd9, 1'b0, 4'b0000}; // CMP2=20
    tbl[4] = '{1'b1, 3'd6, 16'd10,     16'd0, 16'd9, 1'b0, 4'b0000}; // CMP3=10
    tbl[5] = '{1'b1, 3'd7, 16'hFFFF,   16'd0, 16'd9, 1'b0, 4'b0000}; // unmapped
    tbl[6] = '{1'b1, 3'd2, 16'd5,      16'd5, 16'd9, 1'b0, 4'b0000}; // CNT=5
    tbl[7] = '{1'b0, 3'd0, 16'd0,      16'd5, 16'd9, 1'b0, 4'b0000}; // hold
    tbl[8] = '{1'b1, 3'd2, 16'd0,      16'd0, 16'd9, 1'b0, 4'b0000}; // CNT=0
    tbl[9] = '{1'b1, 3'd0, 16'd1,      16'd0, 16'd9, 1'b0, 4'b1101}; // EN=1

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    push_raw(0, 0, 1'b0, 4'b0000);
    check_now("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      push_raw(tbl[i].cnt, tbl[i].top, tbl[i].wrap, tbl[i].out);
      cyc($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata);
    end

    // Free-running edge mode: TOP=9, duty 3/10
    for (int n = 1; n <= 30; n++) begin
      push_edge(n % 10, 9, 3, 1'b1);
      cyc("run", 1'b0, 3'd0, 16'd0);
    end

    // Mid-period CMP0 write: current period keeps 3, next uses 7
    for (int n = 1; n <= 5; n++) begin
      push_edge(n, 9, 3, 1'b1);
      cyc("pre_cmp", 1'b0, 3'd0, 16'd0);
    end
    push_edge(6, 9, 3, 1'b1);
    cyc("wr_cmp7", 1'b1, 3'd3, 16'd7);
    for (int n = 7; n <= 9; n++) begin
      push_edge(n, 9, 3, 1'b1);
      cyc("old_duty", 1'b0, 3'd0, 16'd0);
    end
    for (int n = 0; n <= 9; n++) begin
      push_edge(n, 9, 7, 1'b1);
      cyc("new_duty", 1'b0, 3'd0, 16'd0);
    end

    // Write on the boundary cycle itself: bypass straight to active
    push_edge(0, 9, 2, 1'b1);
    cyc("bypass", 1'b1, 3'd3, 16'd2);
    for (int n = 1; n <= 9; n++) begin
      push_edge(n, 9, 2, 1'b1);
      cyc("bypass_run", 1'b0, 3'd0, 16'd0);
    end

    // Mid-period TOP write: deferred to the boundary
    for (int n = 0; n <= 2; n++) begin
      push_edge(n, 9, 2, 1'b1);
      cyc("pre_top", 1'b0, 3'd0, 16'd0);
    end
    push_edge(3, 9, 2, 1'b1);
    cyc("wr_top4", 1'b1, 3'd1, 16'd4);
    for (int n = 4; n <= 9; n++) begin
      push_edge(n, 9, 2, 1'b1);
      cyc("old_top", 1'b0, 3'd0, 16'd0);
    end
    for (int k = 0; k <= 9; k++) begin
      push_edge(k % 5, 4, 2, 1'b1);
      cyc("top4", 1'b0, 3'd0, 16'd0);
    end

    // CNT load above TOP: holds one cycle with wrap, then 0
    push_edge(50, 4, 2, 1'b1);
    cyc("cnt50", 1'b1, 3'd2, 16'd50);
    push_edge(0, 4, 2, 1'b1);
    cyc("cnt50_next", 1'b0, 3'd0, 16'd0);
    push_edge(1, 4, 2, 1'b1);
    cyc("cnt50_next2", 1'b0, 3'd0, 16'd0);

    // Disable: counter holds, outputs low, TOP loads immediately
    push_edge(2, 4, 2, 1'b0);
    cyc("en_off", 1'b1, 3'd0, 16'd0);
    for (int n = 0; n < 2; n++) begin
      push_edge(2, 4, 2, 1'b0);
      cyc("hold", 1'b0, 3'd0, 16'd0);
    end
    push_edge(2, 9, 2, 1'b0);
    cyc("top_while_off", 1'b1, 3'd1, 16'd9);
    push_edge(2, 9, 2, 1'b1);
    cyc("en_on", 1'b1, 3'd0, 16'd1);
    for (int n = 3; n <= 12; n++) begin
      push_edge(n % 10, 9, 2, 1'b1);
      cyc("resume", 1'b0, 3'd0, 16'd0);
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Center-aligned: TOP=4, CMP0=2 -> 0,1,2,3,4,3,2,1,0,...
    push_edge(3, 9, 2, 1'b0);
    cyc("c_off", 1'b1, 3'd0, 16'd0);
    push_edge(3, 4, 2, 1'b0);
    cyc("c_top", 1'b1, 3'd1, 16'd4);
    push_edge(0, 4, 2, 1'b0);
    cyc("c_cnt0", 1'b1, 3'd2, 16'd0);
    push_raw(0, 4, 1'b0, 4'b1101);
    cyc("c_on", 1'b1, 3'd0, 16'd3);
    for (int n = 1; n <= 10; n++) begin
      int t;
      int c;
      t = n % 8;
      c = (t <= 4) ? t : 8 - t;
      push_raw(c, 4, (t == 0), {(c < 10), (c < 20), 1'b0, (c < 2)});
      cyc("center", 1'b0, 3'd0, 16'd0);
    end
    // Load above TOP while counting up: must turn to down-counting
    push_raw(7, 4, 1'b0, 4'b1100);
    cyc("c_cnt7", 1'b1, 3'd2, 16'd7);
    for (int c = 6; c >= 0; c--) begin
      push_raw(c, 4, (c == 0), {(c < 10), (c < 20), 1'b0, (c < 2)});
      cyc("c_down", 1'b0, 3'd0, 16'd0);
    end
`else
    // CENTER bit ignored: edge wrap at TOP continues
    push_edge(3, 9, 2, 1'b1);
    cyc("ctrl3", 1'b1, 3'd0, 16'd3);
    for (int n = 4; n <= 10; n++) begin
      push_edge(n % 10, 9, 2, 1'b1);
      cyc("no_center", 1'b0, 3'd0, 16'd0);
    end
`endif

    // Asynchronous reset mid-cycle while outputs are high
    #3;
    rst_n = 1'b0;
    #1;
    push_raw(0, 0, 1'b0, 4'b0000);
    check_now("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      push_raw(0, 0, 1'b0, 4'b0000);
      cyc("post_rst", 1'b0, 3'd0, 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
